// File: rtl/div_pkg.sv
// Shared types and constants for the divider front-end: default width,
// status codes and the FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DVZ     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/div_timeout_cnt.sv
// Cycle counter for the WAIT state; tc_o flags the last permitted cycle
// (count == TIMEOUT-1) so the abort can be issued in that same cycle.
module div_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/div_front.sv
// Front-end that feeds one operand pair at a time to an iterative divider,
// catches divide-by-zero locally and aborts the divider if it never answers.
module div_front
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_abort,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [1:0]       out_err,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and a pending result stays stable.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic [WIDTH-1:0] out_r_q, out_r_d;
  logic [1:0]       out_err_q, out_err_d;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;

  div_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clr),
    .enable_i (tmr_en),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    out_q_d   = out_q_q;
    out_r_d   = out_r_q;
    out_err_d = out_err_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          div_a_d = in_a;
          div_b_d = in_b;
          if (in_b == '0) begin
            out_q_d   = '0;
            out_r_d   = '0;
            out_err_d = ERR_DVZ;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the terminal cycle beats the timeout.
        if (div_valid) begin
          out_q_d   = div_q;
          out_r_d   = div_r;
          out_err_d = ERR_OK;
          state_d   = ST_RESP;
        end else if (tmr_tc) begin
          out_q_d   = '0;
          out_r_d   = '0;
          out_err_d = ERR_TIMEOUT;
          state_d   = ST_RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_a_q   <= '0;
      div_b_q   <= '0;
      out_q_q   <= '0;
      out_r_q   <= '0;
      out_err_q <= ERR_OK;
    end else begin
      state_q   <= state_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      out_q_q   <= out_q_d;
      out_r_q   <= out_r_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign div_start = (state_q == ST_ISSUE);
  assign div_abort = (state_q == ST_WAIT) & ~div_valid & tmr_tc;
  assign out_valid = (state_q == ST_RESP);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_q     = out_q_q;
  assign out_r     = out_r_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_front.sv
// Directed bench for div_front: the bench plays the divider by hand and
// checks latency, status codes, back-pressure and asynchronous reset.
module tb_div_front;

  localparam int W  = 10;
  localparam int TO = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_abort;
  logic         div_valid;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
  logic [1:0]   out_err;
  logic [1:0]   dbg_state;

  int n_pass;
  int n_total;
  int start_cnt;
  int abort_cnt;
  int start_base;
  int abort_base;

  div_front #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_abort (div_abort),
    .div_valid (div_valid),
    .div_q     (div_q),
    .div_r     (div_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters, sampled at the edge where the DUT would act on them
  initial begin
    start_cnt = 0;
    abort_cnt = 0;
  end
  always @(posedge clk) begin
    if (div_start) start_cnt++;
    if (div_abort) abort_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // drive one operand pair; returns in cycle 1 after the accepting edge
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    start_base = start_cnt;
    abort_base = abort_cnt;
    in_a       = a;
    in_b       = b;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
  endtask

  task automatic divider_reply(input logic [W-1:0] q, input logic [W-1:0] r);
    div_valid = 1'b1;
    div_q     = q;
    div_r     = r;
    tick();
    div_valid = 1'b0;
    div_q     = '0;
    div_r     = '0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    div_valid = 1'b0;
    div_q     = '0;
    div_r     = '0;
    out_ready = 1'b0;

    // reset state
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_state", 32'(dbg_state), 32'd0);
    check("idle_out_err", 32'(out_err), 32'd0);

    // 100 / 7 = 14 r 2, reply after 12 WAIT cycles -> out_valid at cycle 15
    accept(10'd100, 10'd7);
    check("ok_div_start", 32'(div_start), 32'd1);
    check("ok_in_ready_busy", 32'(in_ready), 32'd0);
    check("ok_div_a", 32'(div_a), 32'd100);
    check("ok_div_b", 32'(div_b), 32'd7);
    repeat (13) tick();
    check("ok_not_yet_c14", 32'(out_valid), 32'd0);
    divider_reply(10'd14, 10'd2);
    check("ok_out_valid_c15", 32'(out_valid), 32'd1);
    check("ok_out_q", 32'(out_q), 32'd14);
    check("ok_out_r", 32'(out_r), 32'd2);
    check("ok_out_err", 32'(out_err), 32'd0);
    check("ok_one_start", 32'(start_cnt - start_base), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ok_back_idle", 32'(in_ready), 32'd1);
    check("ok_out_valid_drop", 32'(out_valid), 32'd0);

    // 55 / 0 -> immediate DVZ, no divider start
    accept(10'd55, 10'd0);
    check("dvz_out_valid_c1", 32'(out_valid), 32'd1);
    check("dvz_out_err", 32'(out_err), 32'd1);
    check("dvz_out_q", 32'(out_q), 32'd0);
    check("dvz_out_r", 32'(out_r), 32'd0);
    check("dvz_div_a", 32'(div_a), 32'd55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dvz_no_start", 32'(start_cnt - start_base), 32'd0);
    check("dvz_back_idle", 32'(in_ready), 32'd1);

    // no reply -> abort on 64th WAIT cycle (cycle 65), result at cycle 66;
    // a stray div_valid during ISSUE must be ignored
    accept(10'd200, 10'd3);
    divider_reply(10'd5, 10'd5);
    repeat (62) tick();
    check("to_no_abort_c64", 32'(div_abort), 32'd0);
    tick();
    check("to_abort_c65", 32'(div_abort), 32'd1);
    tick();
    check("to_out_valid_c66", 32'(out_valid), 32'd1);
    check("to_out_err", 32'(out_err), 32'd2);
    check("to_out_q", 32'(out_q), 32'd0);
    check("to_out_r", 32'(out_r), 32'd0);
    check("to_one_abort", 32'(abort_cnt - abort_base), 32'd1);
    // div_valid during RESP must not disturb the held result
    divider_reply(10'd9, 10'd9);
    check("to_resp_ignore_q", 32'(out_q), 32'd0);
    check("to_resp_ignore_err", 32'(out_err), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reply exactly on the timeout cycle -> completion wins
    accept(10'd9, 10'd2);
    repeat (64) tick();
    div_valid = 1'b1;
    div_q     = 10'd4;
    div_r     = 10'd1;
    #1;
    check("race_abort_low", 32'(div_abort), 32'd0);
    tick();
    div_valid = 1'b0;
    check("race_out_valid_c66", 32'(out_valid), 32'd1);
    check("race_out_err", 32'(out_err), 32'd0);
    check("race_out_q", 32'(out_q), 32'd4);
    check("race_out_r", 32'(out_r), 32'd1);
    check("race_no_abort", 32'(abort_cnt - abort_base), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // back-pressure: k=0 reply -> out_valid at cycle 3, then hold 5 cycles
    accept(10'd17, 10'd5);
    divider_reply(10'd0, 10'd0);
    check("bp_issue_ignored", 32'(out_valid), 32'd0);
    divider_reply(10'd3, 10'd2);
    check("bp_out_valid_c3", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      div_q = 10'h3ff;
      div_r = 10'h3ff;
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_q", 32'(out_q), 32'd3);
      check("bp_hold_r", 32'(out_r), 32'd2);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_div_a", 32'(div_a), 32'd17);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_after", 32'(in_ready), 32'd1);
    check("bp_state_idle", 32'(dbg_state), 32'd0);

    // asynchronous reset in the middle of WAIT
    accept(10'd50, 10'd6);
    repeat (8) tick();
    check("mid_state_wait", 32'(dbg_state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_div_a", 32'(div_a), 32'd0);
    check("mid_rst_div_b", 32'(div_b), 32'd0);
    check("mid_rst_abort", 32'(div_abort), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) tick();
    check("mid_rst_no_abort", 32'(abort_cnt - abort_base), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    accept(10'd30, 10'd4);
    check("post_rst_start", 32'(div_start), 32'd1);
    tick();
    divider_reply(10'd7, 10'd2);
    check("post_rst_valid_c3", 32'(out_valid), 32'd1);
    check("post_rst_q", 32'(out_q), 32'd7);
    check("post_rst_r", 32'(out_r), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_idle", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_front.md
DIV_FRONT -- requirements
Module: div_front

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the operand, quotient and remainder width.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of WAIT cycles before abort (legal range 2..255).
REQ-003 Port clk  input  1  single rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  upstream offers an operand pair.
REQ-006 Port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 Port in_a  input  WIDTH  dividend.
REQ-008 Port in_b  input  WIDTH  divisor.
REQ-009 Port div_start  output  1  one-cycle start pulse to the divider.
REQ-010 Port div_a  output  WIDTH  registered dividend to the divider.
REQ-011 Port div_b  output  WIDTH  registered divisor to the divider.
REQ-012 Port div_abort  output  1  one-cycle synchronous clear to the divider.
REQ-013 Port div_valid  input  1  divider completion pulse (one cycle).
REQ-014 Port div_q  input  WIDTH  divider quotient, sampled only when div_valid=1.
REQ-015 Port div_r  input  WIDTH  divider remainder, sampled only when div_valid=1.
REQ-016 Port out_valid  output  1  result available downstream.
REQ-017 Port out_ready  input  1  downstream accepts the result.
REQ-018 Port out_q  output  WIDTH  quotient.
REQ-019 Port out_r  output  WIDTH  remainder.
REQ-020 Port out_err  output  2  status: 00 OK, 01 DVZ, 10 TIMEOUT; 11 is never driven.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-022 in_ready SHALL be 1 exactly when the state is IDLE; there is no overlap between transactions.
REQ-023 In IDLE, when in_valid=1, the block SHALL latch in_a/in_b into div_a/div_b and go to RESP with err=DVZ and q=r=0 if in_b==0, else go to ISSUE.
REQ-024 In ISSUE, div_start SHALL be 1 for exactly one cycle, the timer SHALL clear to 0, and the FSM SHALL go to WAIT.
REQ-025 In WAIT with div_valid=1, the block SHALL capture div_q/div_r into out_q/out_r, set err=OK and go to RESP.
REQ-026 In WAIT with div_valid=0 and timer==TIMEOUT-1, div_abort SHALL be 1 that cycle, q=r=0, err=TIMEOUT, and the FSM SHALL go to RESP; otherwise the timer SHALL increment.
REQ-027 When div_valid=1 coincides with the timeout cycle, the completion SHALL win (err=OK, no abort).
REQ-028 div_valid outside WAIT SHALL be ignored.
REQ-029 In RESP, out_valid SHALL be 1 and out_q/out_r/out_err SHALL be held stable until out_ready=1, after which the FSM SHALL go to IDLE in the next cycle.
REQ-030 Accept-to-out_valid latency SHALL be 1 cycle for DVZ, 3+k cycles for OK (k = WAIT cycles before div_valid, k≥0), and 2+TIMEOUT cycles for TIMEOUT.
REQ-031 div_a/div_b SHALL remain stable from acceptance until RESP exits.

Reset
REQ-032 When rst_n=0, the state SHALL be IDLE, and div_start, div_abort, out_valid, out_q, out_r, out_err, div_a, div_b and timer SHALL all be 0.
REQ-033 in_ready SHALL be forced to 0 while rst_n=0.
REQ-034 Reset asserted mid-WAIT SHALL not pulse div_abort; the divider is reset by its own reset path.

Structure
REQ-035 Package div_pkg SHALL hold the WIDTH default, the err code constants (OK/DVZ/TIMEOUT) and the state encoding.
REQ-036 The timeout counter SHALL be a sub-module div_timeout_cnt (clear, enable, terminal-count output, parameter TIMEOUT).
REQ-037 The implementation SHALL contain no other sub-modules.

Verification
REQ-038 a=100, b=7, divider returns q=14, r=2 after 12 WAIT cycles -> out_valid at cycle 15 after accept, out_q=14, out_r=2, out_err=00, exactly one div_start.
REQ-039 a=55, b=0 -> no div_start, out_valid on cycle 1, out_err=01, out_q=out_r=0.
REQ-040 Divider never responds, TIMEOUT=64 -> div_abort pulse on the 64th WAIT cycle, out_err=10, out_valid at cycle 66.
REQ-041 div_valid arrives on the exact timeout cycle -> out_err=00 and div_abort stays 0.
REQ-042 out_ready held 0 for 5 cycles in RESP -> outputs stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-043 rst_n pulled low mid-WAIT -> all outputs 0 immediately (asynchronous), no div_abort; after release, a new operand pair is accepted normally.
